// File: rtl/umstr_ethii_arbiter.sv
// Round-robin arbiter that feeds one Ethernet II packer from N requesters.
// Each grant covers one header plus one payload packet from a single channel.
module umstr_ethii_arbiter #(
    parameter int N = 4,
    parameter int DATA_W = 64,
    localparam int KEEP_W = DATA_W / 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N*48-1:0]     req_mac_dest_i,
    input  logic [N*48-1:0]     req_mac_src_i,
    input  logic [N*16-1:0]     req_mac_type_i,
    input  logic [N-1:0]        req_hdr_vld_i,
    output logic [N-1:0]        req_hdr_rdy_o,
    input  logic [N*DATA_W-1:0] req_tdata_i,
    input  logic [N*KEEP_W-1:0] req_tkeep_i,
    input  logic [N-1:0]        req_tvld_i,
    input  logic [N-1:0]        req_tlast_i,
    output logic [N-1:0]        req_trdy_o,
    output logic [47:0]         hdr_mac_dest_o,
    output logic [47:0]         hdr_mac_src_o,
    output logic [15:0]         hdr_mac_type_o,
    output logic                hdr_mac_vld_o,
    input  logic                hdr_mac_rdy_i,
    output logic [DATA_W-1:0]   user_tdata_o,
    output logic [KEEP_W-1:0]   user_tkeep_o,
    output logic                user_tvld_o,
    output logic                user_tlast_o,
    input  logic                user_trdy_i,
    output logic [N-1:0]        grant_o
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, BUSY, HDR_WAIT} state_t;

    state_t        state, state_n;
    logic [N-1:0]  grant, grant_n;
    logic [IW-1:0] gidx, gidx_n;
    logic [IW-1:0] rr_ptr, rr_ptr_n;
    logic          hdr_done, hdr_done_n;

    logic              found;
    logic [IW-1:0]     pick;
    logic [IW:0]       cand;
    logic [IW:0]       g_inc;
    logic [IW-1:0]     rr_next;
    logic              owned, pay_on, hdr_hs, last_beat;
    logic              sel_hvld, sel_tvld, sel_tlast;
    logic [DATA_W-1:0] sel_tdata;
    logic [KEEP_W-1:0] sel_tkeep;

    // First requesting channel at or after rr_ptr, wrapping modulo N
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N))
                cand = cand - (IW+1)'(N);
            if (!found && req_hdr_vld_i[cand[IW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IW-1:0];
            end
        end
    end

    // Round-robin pointer for the channel after the current owner
    always_comb begin
        g_inc   = {1'b0, gidx} + (IW+1)'(1);
        rr_next = (g_inc >= (IW+1)'(N)) ? '0 : g_inc[IW-1:0];
    end

    // One-hot mux of the owner's lanes; all zero while nobody owns the port
    always_comb begin
        hdr_mac_dest_o = '0;
        hdr_mac_src_o  = '0;
        hdr_mac_type_o = '0;
        sel_hvld       = 1'b0;
        sel_tvld       = 1'b0;
        sel_tlast      = 1'b0;
        sel_tdata      = '0;
        sel_tkeep      = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                hdr_mac_dest_o = req_mac_dest_i[48*i +: 48];
                hdr_mac_src_o  = req_mac_src_i[48*i +: 48];
                hdr_mac_type_o = req_mac_type_i[16*i +: 16];
                sel_hvld       = req_hdr_vld_i[i];
                sel_tvld       = req_tvld_i[i];
                sel_tlast      = req_tlast_i[i];
                sel_tdata      = req_tdata_i[DATA_W*i +: DATA_W];
                sel_tkeep      = req_tkeep_i[KEEP_W*i +: KEEP_W];
            end
        end
    end

    assign owned  = (state != IDLE);
    assign pay_on = (state == BUSY);

    assign hdr_mac_vld_o = owned & sel_hvld & ~hdr_done;
    assign req_hdr_rdy_o = grant & {N{owned & hdr_mac_rdy_i & ~hdr_done}};
    assign user_tvld_o   = pay_on & sel_tvld;
    assign user_tlast_o  = pay_on & sel_tlast;
    assign user_tdata_o  = pay_on ? sel_tdata : '0;
    assign user_tkeep_o  = pay_on ? sel_tkeep : '0;
    assign req_trdy_o    = grant & {N{pay_on & user_trdy_i}};
    assign grant_o       = grant;

    assign hdr_hs    = hdr_mac_vld_o & hdr_mac_rdy_i;
    assign last_beat = user_tvld_o & user_trdy_i & user_tlast_o;

    // State, owner and header-done flag; reset abandons any packet in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            gidx     <= '0;
            rr_ptr   <= '0;
            hdr_done <= 1'b0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            gidx     <= gidx_n;
            rr_ptr   <= rr_ptr_n;
            hdr_done <= hdr_done_n;
        end
    end

    // Grant in IDLE; release once both header and tlast beat have gone
    always_comb begin
        state_n    = state;
        grant_n    = grant;
        gidx_n     = gidx;
        rr_ptr_n   = rr_ptr;
        hdr_done_n = hdr_done;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = BUSY;
                    grant_n = {{(N-1){1'b0}}, 1'b1} << pick;
                    gidx_n  = pick;
                end
            end
            BUSY: begin
                if (hdr_hs)
                    hdr_done_n = 1'b1;
                if (last_beat) begin
                    if (hdr_done || hdr_hs) begin
                        state_n    = IDLE;
                        grant_n    = '0;
                        rr_ptr_n   = rr_next;
                        hdr_done_n = 1'b0;
                    end else begin
                        state_n = HDR_WAIT;
                    end
                end
            end
            HDR_WAIT: begin
                if (hdr_hs) begin
                    state_n    = IDLE;
                    grant_n    = '0;
                    rr_ptr_n   = rr_next;
                    hdr_done_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_umstr_ethii_arbiter.sv
// Bench for umstr_ethii_arbiter: packet-level reference model,
// randomized requesters and directed arbitration scenarios.
module tb_umstr_ethii_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = DW / 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N*48-1:0] req_mac_dest_i, req_mac_src_i;
    logic [N*16-1:0] req_mac_type_i;
    logic [N-1:0]    req_hdr_vld_i, req_hdr_rdy_o;
    logic [N*DW-1:0] req_tdata_i;
    logic [N*KW-1:0] req_tkeep_i;
    logic [N-1:0]    req_tvld_i, req_tlast_i, req_trdy_o;
    logic [47:0]     hdr_mac_dest_o, hdr_mac_src_o;
    logic [15:0]     hdr_mac_type_o;
    logic            hdr_mac_vld_o, hdr_mac_rdy_i;
    logic [DW-1:0]   user_tdata_o;
    logic [KW-1:0]   user_tkeep_o;
    logic            user_tvld_o, user_tlast_o, user_trdy_i;
    logic [N-1:0]    grant_o;

    always #5 clk = ~clk;

    umstr_ethii_arbiter #(.N(N), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req_mac_dest_i(req_mac_dest_i), .req_mac_src_i(req_mac_src_i),
        .req_mac_type_i(req_mac_type_i), .req_hdr_vld_i(req_hdr_vld_i),
        .req_hdr_rdy_o(req_hdr_rdy_o), .req_tdata_i(req_tdata_i),
        .req_tkeep_i(req_tkeep_i), .req_tvld_i(req_tvld_i),
        .req_tlast_i(req_tlast_i), .req_trdy_o(req_trdy_o),
        .hdr_mac_dest_o(hdr_mac_dest_o), .hdr_mac_src_o(hdr_mac_src_o),
        .hdr_mac_type_o(hdr_mac_type_o), .hdr_mac_vld_o(hdr_mac_vld_o),
        .hdr_mac_rdy_i(hdr_mac_rdy_i), .user_tdata_o(user_tdata_o),
        .user_tkeep_o(user_tkeep_o), .user_tvld_o(user_tvld_o),
        .user_tlast_o(user_tlast_o), .user_trdy_i(user_trdy_i),
        .grant_o(grant_o)
    );

    int vectors = 0;
    int miscompares = 0;

    // requester sources
    int            budget[N];
    int            left[N];
    bit            busy[N];
    bit            s_hvld[N], s_tvld[N], s_last[N];
    logic [47:0]   s_dest[N], s_src[N];
    logic [15:0]   s_type[N];
    logic [DW-1:0] s_data[N];
    logic [KW-1:0] s_keep[N];
    int plen = 1, p_trdy = 100, p_hrdy = 100, p_vld = 100, p_start = 100;

    // packet-level reference: owner (-1 = none), header sent, payload done
    int m_owner = -1;
    int m_rr = 0;
    bit m_hdr, m_pay;
    int exp_beats, exp_hdrs, out_beats, out_hdrs;

    // observed grant history
    logic [N-1:0] gseq[$];
    int           gaps[$];
    int           gap_cnt;
    logic [N-1:0] prev_grant;
    int           last_at;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pct(int p);
        return int'($urandom_range(99)) < p;
    endfunction

    function automatic logic [N-1:0] gat(int k);
        return (gseq.size() > k) ? gseq[k] : '0;
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_mac_dest_i[48*i +: 48] = s_dest[i];
            req_mac_src_i[48*i +: 48]  = s_src[i];
            req_mac_type_i[16*i +: 16] = s_type[i];
            req_hdr_vld_i[i]           = s_hvld[i];
            req_tdata_i[DW*i +: DW]    = s_data[i];
            req_tkeep_i[KW*i +: KW]    = s_keep[i];
            req_tvld_i[i]              = s_tvld[i];
            req_tlast_i[i]             = s_last[i];
        end
        user_trdy_i   = pct(p_trdy);
        hdr_mac_rdy_i = pct(p_hrdy);
    endtask

    task automatic new_beat(int i);
        s_tvld[i] = 1'b1;
        s_data[i] = {$urandom, $urandom};
        s_keep[i] = KW'($urandom);
        s_last[i] = (left[i] == 1);
    endtask

    // one clock: compare mid-cycle, then advance model and sources
    task automatic step();
        logic [N-1:0] e_grant, e_hrdy, e_trdy;
        bit e_hvld, e_uvld, hs, beat, got;
        int o, c;
        #3;
        o = m_owner;
        e_grant = '0;
        e_hrdy  = '0;
        e_trdy  = '0;
        e_hvld  = 1'b0;
        e_uvld  = 1'b0;
        if (o >= 0) begin
            e_grant[o] = 1'b1;
            if (!m_hdr) begin
                e_hvld    = s_hvld[o];
                e_hrdy[o] = hdr_mac_rdy_i;
            end
            if (!m_pay) begin
                e_uvld    = s_tvld[o];
                e_trdy[o] = user_trdy_i;
            end
        end
        chk("grant", grant_o, e_grant);
        chk("hdr_vld", hdr_mac_vld_o, e_hvld);
        chk("hdr_rdy", req_hdr_rdy_o, e_hrdy);
        chk("user_tvld", user_tvld_o, e_uvld);
        chk("req_trdy", req_trdy_o, e_trdy);
        if (e_hvld) begin
            chk("hdr_dest", hdr_mac_dest_o, s_dest[o]);
            chk("hdr_src", hdr_mac_src_o, s_src[o]);
            chk("hdr_type", hdr_mac_type_o, s_type[o]);
        end
        if (e_uvld) begin
            chk("tdata", user_tdata_o, s_data[o]);
            chk("tkeep", user_tkeep_o, s_keep[o]);
            chk("tlast", user_tlast_o, s_last[o]);
        end
        hs   = e_hvld && hdr_mac_rdy_i;
        beat = e_uvld && user_trdy_i;
        if (hdr_mac_vld_o && hdr_mac_rdy_i) out_hdrs++;
        if (user_tvld_o && user_trdy_i) begin
            out_beats++;
            if (user_tlast_o) last_at = out_beats;
        end
        if (grant_o != '0 && prev_grant == '0) begin
            if (gseq.size() > 0) gaps.push_back(gap_cnt);
            gseq.push_back(grant_o);
            gap_cnt = 0;
        end else if (grant_o == '0 && gseq.size() > 0) begin
            gap_cnt++;
        end
        prev_grant = grant_o;
        @(posedge clk);
        #1;
        if (o < 0) begin
            got = 1'b0;
            for (int k = 0; k < N; k++) begin
                c = (m_rr + k) % N;
                if (!got && s_hvld[c]) begin
                    got     = 1'b1;
                    m_owner = c;
                    m_hdr   = 1'b0;
                    m_pay   = 1'b0;
                end
            end
        end else begin
            if (hs) begin
                m_hdr = 1'b1;
                exp_hdrs++;
                s_hvld[o] = 1'b0;
            end
            if (beat) begin
                exp_beats++;
                if (s_last[o]) m_pay = 1'b1;
                left[o]--;
                s_tvld[o] = 1'b0;
                s_last[o] = 1'b0;
            end
            if (m_hdr && m_pay) begin
                m_rr    = (o + 1) % N;
                m_owner = -1;
            end
            if (!s_hvld[o] && left[o] == 0) busy[o] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (!busy[i] && budget[i] > 0 && pct(p_start)) begin
                busy[i]   = 1'b1;
                budget[i]--;
                left[i]   = (plen > 0) ? plen : int'($urandom_range(1, 4));
                s_hvld[i] = 1'b1;
                s_dest[i] = {16'($urandom), $urandom};
                s_src[i]  = {16'($urandom), $urandom};
                s_type[i] = 16'($urandom);
            end
            if (busy[i] && left[i] > 0 && !s_tvld[i] && pct(p_vld))
                new_beat(i);
        end
        apply();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            budget[i] = 0;
            left[i]   = 0;
            busy[i]   = 1'b0;
            s_hvld[i] = 1'b0;
            s_tvld[i] = 1'b0;
            s_last[i] = 1'b0;
            s_dest[i] = '0;
            s_src[i]  = '0;
            s_type[i] = '0;
            s_data[i] = '0;
            s_keep[i] = '0;
        end
        m_owner = -1;
        m_rr    = 0;
        m_hdr   = 1'b0;
        m_pay   = 1'b0;
        exp_beats = 0;
        exp_hdrs  = 0;
        out_beats = 0;
        out_hdrs  = 0;
        gseq.delete();
        gaps.delete();
        gap_cnt    = 0;
        prev_grant = '0;
        last_at    = 0;
        plen = 1;
        p_trdy = 100;
        p_hrdy = 100;
        p_vld = 100;
        p_start = 100;
        apply();
        #1;
        chk("rst_grant", grant_o, 0);
        chk("rst_hdr_vld", hdr_mac_vld_o, 0);
        chk("rst_user_tvld", user_tvld_o, 0);
        chk("rst_hdr_rdy", req_hdr_rdy_o, 0);
        chk("rst_trdy", req_trdy_o, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] expb[5];
        int t;
        expb = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // single 3-beat packet on ch1
        do_reset();
        budget[1] = 1;
        plen = 3;
        repeat (12) step();
        chk("a_ngrants", gseq.size(), 1);
        chk("a_grant", gat(0), 4'b0010);
        chk("a_beats", out_beats, 3);
        chk("a_hdrs", out_hdrs, 1);
        chk("a_last_at", last_at, 3);
        chk("a_rr", m_rr, 2);
        #1;
        chk("a_idle", grant_o, 0);

        // all four requesting, 2-beat packets
        do_reset();
        budget = '{2, 1, 1, 1};
        plen = 2;
        repeat (30) step();
        chk("b_ngrants", gseq.size(), 5);
        for (int k = 0; k < 5; k++) chk("b_order", gat(k), expb[k]);
        chk("b_ngaps", gaps.size(), 4);
        foreach (gaps[k]) chk("b_gap", gaps[k], 1);

        // header held off past the tlast beat
        do_reset();
        budget[2] = 1;
        plen = 1;
        p_hrdy = 0;
        t = 0;
        while (t < 20 && !(m_owner == 2 && m_pay)) begin
            step();
            t++;
        end
        chk("c_reached", (m_owner == 2 && m_pay), 1);
        #1;
        chk("c_grant", grant_o, 4'b0100);
        chk("c_tvld", user_tvld_o, 0);
        chk("c_hvld", hdr_mac_vld_o, 1);
        p_hrdy = 100;
        apply();
        step();
        chk("c_hdrs", out_hdrs, 1);
        #1;
        chk("c_idle", grant_o, 0);

        // late request from ch3 while ch0 busy
        do_reset();
        budget[0] = 1;
        plen = 4;
        repeat (3) step();
        budget[3] = 1;
        repeat (20) step();
        chk("d_ngrants", gseq.size(), 2);
        chk("d_first", gat(0), 4'b0001);
        chk("d_second", gat(1), 4'b1000);
        chk("d_gap", (gaps.size() > 0) ? gaps[0] : -1, 1);

        // 10-beat packet with random backpressure
        do_reset();
        budget[1] = 1;
        plen = 10;
        p_trdy = 50;
        p_vld = 70;
        t = 0;
        while (t < 200 && exp_beats < 10) begin
            step();
            t++;
        end
        repeat (4) step();
        chk("e_model_beats", exp_beats, 10);
        chk("e_beats", out_beats, 10);
        chk("e_last_at", last_at, 10);
        chk("e_hdrs", out_hdrs, 1);

        // asynchronous reset during beat 2
        do_reset();
        budget[2] = 1;
        plen = 4;
        t = 0;
        while (t < 20 && exp_beats < 1) begin
            step();
            t++;
        end
        #1;
        chk("f_beat2", user_tvld_o, 1);
        reset = 1'b1;
        #1;
        chk("f_grant", grant_o, 0);
        chk("f_hdr_vld", hdr_mac_vld_o, 0);
        chk("f_tvld", user_tvld_o, 0);
        chk("f_trdy", req_trdy_o, 0);
        chk("f_hdr_rdy", req_hdr_rdy_o, 0);
        do_reset();
        budget[0] = 1;
        budget[2] = 1;
        plen = 2;
        repeat (15) step();
        chk("f_first", gat(0), 4'b0001);
        chk("f_second", gat(1), 4'b0100);

        // randomized traffic
        do_reset();
        for (int i = 0; i < N; i++) budget[i] = 10000;
        plen = 0;
        p_trdy = 70;
        p_hrdy = 60;
        p_vld = 80;
        p_start = 60;
        repeat (1500) step();
        chk("r_beats", out_beats, exp_beats);
        chk("r_hdrs", out_hdrs, exp_hdrs);
        chk("r_traffic", exp_hdrs > 20, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/umstr_ethii_arbiter.md
UMSTR_ETHII_ARBITER -- requirements
Module: umstr_ethii_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requester channels (2..8).
REQ-002 SHALL have parameter DATA_W, default 64, stream data width in bits; KEEP_W = DATA_W/8.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_mac_dest_i, input, N*48, per-channel destination MAC; channel i at bits [48i+47:48i].
REQ-006 SHALL have port req_mac_src_i, input, N*48, per-channel source MAC, packed as REQ-005.
REQ-007 SHALL have port req_mac_type_i, input, N*16, per-channel EtherType.
REQ-008 SHALL have port req_hdr_vld_i, input, N, per-channel header valid.
REQ-009 SHALL have port req_hdr_rdy_o, output, N, per-channel header ready.
REQ-010 SHALL have ports req_tdata_i (N*DATA_W), req_tkeep_i (N*KEEP_W), req_tvld_i (N), req_tlast_i (N) as inputs and req_trdy_o (N) as output, forming per-channel payload streams.
REQ-011 SHALL have ports hdr_mac_dest_o (48), hdr_mac_src_o (48), hdr_mac_type_o (16), hdr_mac_vld_o (1) as outputs and hdr_mac_rdy_i (1) as input, the header port to the Ethernet II packer.
REQ-012 SHALL have ports user_tdata_o (DATA_W), user_tkeep_o (KEEP_W), user_tvld_o, user_tlast_o as outputs and user_trdy_i as input, the payload port to the packer.
REQ-013 SHALL have port grant_o, output, N, one-hot current owner; all-zero when idle.

Function
REQ-014 SHALL implement states IDLE, BUSY, HDR_WAIT.
REQ-015 In IDLE, SHALL grant the first channel with req_hdr_vld_i=1, searching from rr_ptr upward modulo N; grant_o and state BUSY are registered, so hdr_mac_vld_o rises 1 cycle after the request is sampled.
REQ-016 In IDLE, SHALL drive hdr_mac_vld_o=0, user_tvld_o=0, req_hdr_rdy_o=0, req_trdy_o=0.
REQ-017 In BUSY, SHALL mux the granted channel's header to the header port while hdr_done=0; hdr_mac_vld_o = req_hdr_vld_i[g] & ~hdr_done; req_hdr_rdy_o[g] = hdr_mac_rdy_i & ~hdr_done; other channels see 0.
REQ-018 SHALL set hdr_done on the header handshake (vld&rdy) and clear it on leaving BUSY/HDR_WAIT.
REQ-019 In BUSY, SHALL pass the granted payload combinationally: user_t* = req_t*[g], req_trdy_o[g] = user_trdy_i, other req_trdy_o = 0; payload may transfer before, with, or after the header handshake.
REQ-020 On accepted tlast beat in BUSY: if hdr_done=1 or the header handshake occurs in the same cycle, SHALL go to IDLE; otherwise go to HDR_WAIT.
REQ-021 In HDR_WAIT, SHALL hold user_tvld_o=0 and all req_trdy_o=0, present the header as in REQ-017, and go to IDLE on header handshake.
REQ-022 On returning to IDLE, SHALL set rr_ptr = (g+1) mod N; there is exactly one idle cycle between packets.
REQ-023 SHALL never change grant_o while in BUSY or HDR_WAIT, regardless of other requests.
REQ-024 SHALL treat req_tkeep_i as opaque, forwarding it unchanged.

Reset
REQ-025 While reset=1, SHALL force state IDLE, grant_o=0, rr_ptr=0, hdr_done=0; all valid/ready outputs 0 asynchronously.
REQ-026 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration restarts from channel 0.

Verification
REQ-027 Single request: ch1 header+3-beat packet, user_trdy_i=1 -> grant_o=0010, one header handshake, 3 beats out, tlast on beat 3, IDLE next cycle, rr_ptr=2.
REQ-028 All four channels request continuously, 2-beat packets -> grants in order 0,1,2,3,0 with exactly one idle cycle between packets.
REQ-029 ch2 granted, hdr_mac_rdy_i held 0 while 1-beat packet with tlast accepted -> state HDR_WAIT, user_tvld_o=0; hdr_mac_rdy_i=1 -> header handshake, IDLE next cycle.
REQ-030 ch0 busy, ch3 raises request mid-packet -> grant_o stays 0001 until ch0 tlast accepted, then 1000 after the idle cycle.
REQ-031 user_trdy_i toggled randomly on ch1 10-beat packet -> output data/keep/last bit-identical to input, no beat lost or duplicated.
REQ-032 reset pulsed during beat 2 of ch2 packet -> all outputs 0 immediately; after release, ch0 and ch2 requesting -> ch0 granted first.
